armleo_axi_mux_ooo: RTL

- N-host to 1-client AXI4 multiplexer with multiple outstanding transactions per direction.
- Tags each downstream ID with the granting host index. R and B responses are routed back by ID, so hosts may interleave.
- AR and AW arbitration are independent round-robin. W data is steered by an AW-order index FIFO.
- Sits between CPU/DMA hosts and the interconnect or memory client.

---
 rtl/armleo_axi_mux_ooo.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/armleo_axi_mux_ooo.sv
// armleo_axi_mux_ooo: N-host to 1-client AXI4 multiplexer with multiple outstanding transactions.
// Ports: clk, rst_n (async active-low); upstream_axi_{aw,w,b,ar,r}* are per-host packed arrays
// (index = host); downstream_axi_{aw,w,b,ar,r}* is the single client port, IDs prefixed with the host index.
module armleo_axi_mux_ooo #(
  parameter int HOST_NUMBER = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int W_FIFO_DEPTH = 4,
  localparam int HIDX_W = (HOST_NUMBER > 1) ? $clog2(HOST_NUMBER) : 1,
  localparam int DATA_STROBES = DATA_WIDTH / 8,
  localparam int DS_ID_WIDTH = ID_WIDTH + HIDX_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [HOST_NUMBER-1:0] upstream_axi_awvalid,
  output logic [HOST_NUMBER-1:0] upstream_axi_awready,
  input  logic [HOST_NUMBER-1:0][ADDR_WIDTH-1:0] upstream_axi_awaddr,
  input  logic [HOST_NUMBER-1:0][7:0] upstream_axi_awlen,
  input  logic [HOST_NUMBER-1:0][2:0] upstream_axi_awsize,
  input  logic [HOST_NUMBER-1:0][1:0] upstream_axi_awburst,
  input  logic [HOST_NUMBER-1:0] upstream_axi_awlock,
  input  logic [HOST_NUMBER-1:0][ID_WIDTH-1:0] upstream_axi_awid,
  input  logic [HOST_NUMBER-1:0][2:0] upstream_axi_awprot,
  input  logic [HOST_NUMBER-1:0] upstream_axi_wvalid,
  output logic [HOST_NUMBER-1:0] upstream_axi_wready,
  input  logic [HOST_NUMBER-1:0][DATA_WIDTH-1:0] upstream_axi_wdata,
  input  logic [HOST_NUMBER-1:0][DATA_STROBES-1:0] upstream_axi_wstrb,
  input  logic [HOST_NUMBER-1:0] upstream_axi_wlast,
  output logic [HOST_NUMBER-1:0] upstream_axi_bvalid,
  input  logic [HOST_NUMBER-1:0] upstream_axi_bready,
  output logic [HOST_NUMBER-1:0][1:0] upstream_axi_bresp,
  output logic [HOST_NUMBER-1:0][ID_WIDTH-1:0] upstream_axi_bid,
  input  logic [HOST_NUMBER-1:0] upstream_axi_arvalid,
  output logic [HOST_NUMBER-1:0] upstream_axi_arready,
  input  logic [HOST_NUMBER-1:0][ADDR_WIDTH-1:0] upstream_axi_araddr,
  input  logic [HOST_NUMBER-1:0][7:0] upstream_axi_arlen,
  input  logic [HOST_NUMBER-1:0][2:0] upstream_axi_arsize,
  input  logic [HOST_NUMBER-1:0][1:0] upstream_axi_arburst,
  input  logic [HOST_NUMBER-1:0] upstream_axi_arlock,
  input  logic [HOST_NUMBER-1:0][ID_WIDTH-1:0] upstream_axi_arid,
  input  logic [HOST_NUMBER-1:0][2:0] upstream_axi_arprot,
  output logic [HOST_NUMBER-1:0] upstream_axi_rvalid,
  input  logic [HOST_NUMBER-1:0] upstream_axi_rready,
  output logic [HOST_NUMBER-1:0][1:0] upstream_axi_rresp,
  output logic [HOST_NUMBER-1:0] upstream_axi_rlast,
  output logic [HOST_NUMBER-1:0][DATA_WIDTH-1:0] upstream_axi_rdata,
  output logic [HOST_NUMBER-1:0][ID_WIDTH-1:0] upstream_axi_rid,
  output logic downstream_axi_awvalid,
  input  logic downstream_axi_awready,
  output logic [ADDR_WIDTH-1:0] downstream_axi_awaddr,
  output logic [7:0] downstream_axi_awlen,
  output logic [2:0] downstream_axi_awsize,
  output logic [1:0] downstream_axi_awburst,
  output logic downstream_axi_awlock,
  output logic [DS_ID_WIDTH-1:0] downstream_axi_awid,
  output logic [2:0] downstream_axi_awprot,
  output logic downstream_axi_wvalid,
  input  logic downstream_axi_wready,
  output logic [DATA_WIDTH-1:0] downstream_axi_wdata,
  output logic [DATA_STROBES-1:0] downstream_axi_wstrb,
  output logic downstream_axi_wlast,
  input  logic downstream_axi_bvalid,
  output logic downstream_axi_bready,
  input  logic [1:0] downstream_axi_bresp,
  input  logic [DS_ID_WIDTH-1:0] downstream_axi_bid,
  output logic downstream_axi_arvalid,
  input  logic downstream_axi_arready,
  output logic [ADDR_WIDTH-1:0] downstream_axi_araddr,
  output logic [7:0] downstream_axi_arlen,
  output logic [2:0] downstream_axi_arsize,
  output logic [1:0] downstream_axi_arburst,
  output logic downstream_axi_arlock,
  output logic [DS_ID_WIDTH-1:0] downstream_axi_arid,
  output logic [2:0] downstream_axi_arprot,
  input  logic downstream_axi_rvalid,
  output logic downstream_axi_rready,
  input  logic [1:0] downstream_axi_rresp,
  input  logic downstream_axi_rlast,
  input  logic [DATA_WIDTH-1:0] downstream_axi_rdata,
  input  logic [DS_ID_WIDTH-1:0] downstream_axi_rid
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int FP_W = $clog2(W_FIFO_DEPTH);
  localparam int QC_W = FP_W + 1;
  localparam int HSPACE = 1 << HIDX_W;
  // Host-index values that map to a real host; the rest are illegal response IDs.
  localparam logic [HSPACE-1:0] LEGAL = {HSPACE{1'b1}} >> (HSPACE - HOST_NUMBER);

  // First requester at or after ptr, wrapping around the host ring.
  function automatic logic [HIDX_W-1:0] rr_pick(input logic [HOST_NUMBER-1:0] req, input logic [HIDX_W-1:0] ptr);
    logic [HIDX_W-1:0] pick, h;
    pick = ptr;
    for (int k = HOST_NUMBER - 1; k >= 0; k--) begin
      h = HIDX_W'((int'(ptr) + k) % HOST_NUMBER);
      if (req[h]) pick = h;
    end
    return pick;
  endfunction

  logic ar_hold, ar_act, ar_hs, r_done, r_ok;
  logic [HIDX_W-1:0] ar_idx, ar_ptr, ar_sel, r_host;
  logic [CNT_W-1:0] ar_cnt;
  logic aw_hold, aw_act, aw_hs, b_done, b_ok, w_pop, wq_empty, wq_full;
  logic [HIDX_W-1:0] aw_idx, aw_ptr, aw_sel, b_host, w_head;
  logic [CNT_W-1:0] aw_cnt;
  logic [W_FIFO_DEPTH-1:0][HIDX_W-1:0] wq;
  logic [FP_W-1:0] wq_wr, wq_rd;
  logic [QC_W-1:0] wq_cnt;

  // Read address: a held grant survives client back-pressure; new grants need counter room.
  always_comb begin
    ar_sel = ar_hold ? ar_idx : rr_pick(upstream_axi_arvalid, ar_ptr);
    ar_act = rst_n && (ar_hold || (ar_cnt < CNT_W'(MAX_OUTSTANDING) && |upstream_axi_arvalid));
  end

  assign downstream_axi_arvalid = ar_act;
  assign downstream_axi_araddr = upstream_axi_araddr[ar_sel];
  assign downstream_axi_arlen = upstream_axi_arlen[ar_sel];
  assign downstream_axi_arsize = upstream_axi_arsize[ar_sel];
  assign downstream_axi_arburst = upstream_axi_arburst[ar_sel];
  assign downstream_axi_arlock = upstream_axi_arlock[ar_sel];
  assign downstream_axi_arprot = upstream_axi_arprot[ar_sel];
  assign downstream_axi_arid = {ar_sel, upstream_axi_arid[ar_sel]};
  assign upstream_axi_arready = (ar_act && downstream_axi_arready) ? HOST_NUMBER'(1) << ar_sel : '0;
  assign ar_hs = downstream_axi_arvalid && downstream_axi_arready;

  // Read data: routed by the host tag in the ID, payload broadcast.
  assign r_host = downstream_axi_rid[DS_ID_WIDTH-1:ID_WIDTH];
  assign r_ok = LEGAL[r_host];
  assign upstream_axi_rvalid = (rst_n && downstream_axi_rvalid && r_ok) ? HOST_NUMBER'(1) << r_host : '0;
  assign downstream_axi_rready = rst_n && (!r_ok || upstream_axi_rready[r_host]);
  assign upstream_axi_rid = {HOST_NUMBER{downstream_axi_rid[ID_WIDTH-1:0]}};
  assign upstream_axi_rdata = {HOST_NUMBER{downstream_axi_rdata}};
  assign upstream_axi_rresp = {HOST_NUMBER{downstream_axi_rresp}};
  assign upstream_axi_rlast = {HOST_NUMBER{downstream_axi_rlast}};
  assign r_done = downstream_axi_rvalid && downstream_axi_rready && downstream_axi_rlast;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ar_hold <= 1'b0;
      ar_idx <= '0;
      ar_ptr <= '0;
      ar_cnt <= '0;
    end else begin
      ar_hold <= downstream_axi_arvalid && !downstream_axi_arready;
      ar_idx <= ar_sel;
      if (ar_hs) ar_ptr <= HIDX_W'((int'(ar_sel) + 1) % HOST_NUMBER);
      ar_cnt <= ar_cnt + CNT_W'(ar_hs) - CNT_W'(r_done);
    end

  // Write address: a full steering FIFO still admits a grant when its head pops this cycle.
  always_comb begin
    aw_sel = aw_hold ? aw_idx : rr_pick(upstream_axi_awvalid, aw_ptr);
    aw_act = rst_n && (aw_hold || (aw_cnt < CNT_W'(MAX_OUTSTANDING) && (!wq_full || w_pop) && |upstream_axi_awvalid));
  end

  assign downstream_axi_awvalid = aw_act;
  assign downstream_axi_awaddr = upstream_axi_awaddr[aw_sel];
  assign downstream_axi_awlen = upstream_axi_awlen[aw_sel];
  assign downstream_axi_awsize = upstream_axi_awsize[aw_sel];
  assign downstream_axi_awburst = upstream_axi_awburst[aw_sel];
  assign downstream_axi_awlock = upstream_axi_awlock[aw_sel];
  assign downstream_axi_awprot = upstream_axi_awprot[aw_sel];
  assign downstream_axi_awid = {aw_sel, upstream_axi_awid[aw_sel]};
  assign upstream_axi_awready = (aw_act && downstream_axi_awready) ? HOST_NUMBER'(1) << aw_sel : '0;
  assign aw_hs = downstream_axi_awvalid && downstream_axi_awready;

  // Write data: the FIFO head (registered, so never the same-cycle AW) owns the W channel.
  assign wq_empty = wq_cnt == '0;
  assign wq_full = wq_cnt == QC_W'(W_FIFO_DEPTH);
  assign w_head = wq[wq_rd];
  assign downstream_axi_wvalid = rst_n && !wq_empty && upstream_axi_wvalid[w_head];
  assign downstream_axi_wdata = upstream_axi_wdata[w_head];
  assign downstream_axi_wstrb = upstream_axi_wstrb[w_head];
  assign downstream_axi_wlast = upstream_axi_wlast[w_head];
  assign upstream_axi_wready = (rst_n && !wq_empty && downstream_axi_wready) ? HOST_NUMBER'(1) << w_head : '0;
  assign w_pop = downstream_axi_wvalid && downstream_axi_wready && downstream_axi_wlast;

  // Write response: same routing rules as read data.
  assign b_host = downstream_axi_bid[DS_ID_WIDTH-1:ID_WIDTH];
  assign b_ok = LEGAL[b_host];
  assign upstream_axi_bvalid = (rst_n && downstream_axi_bvalid && b_ok) ? HOST_NUMBER'(1) << b_host : '0;
  assign downstream_axi_bready = rst_n && (!b_ok || upstream_axi_bready[b_host]);
  assign upstream_axi_bid = {HOST_NUMBER{downstream_axi_bid[ID_WIDTH-1:0]}};
  assign upstream_axi_bresp = {HOST_NUMBER{downstream_axi_bresp}};
  assign b_done = downstream_axi_bvalid && downstream_axi_bready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      aw_hold <= 1'b0;
      aw_idx <= '0;
      aw_ptr <= '0;
      aw_cnt <= '0;
      wq <= '0;
      wq_wr <= '0;
      wq_rd <= '0;
      wq_cnt <= '0;
    end else begin
      aw_hold <= downstream_axi_awvalid && !downstream_axi_awready;
      aw_idx <= aw_sel;
      if (aw_hs) aw_ptr <= HIDX_W'((int'(aw_sel) + 1) % HOST_NUMBER);
      aw_cnt <= aw_cnt + CNT_W'(aw_hs) - CNT_W'(b_done);
      if (aw_hs) wq[wq_wr] <= aw_sel;
      if (aw_hs) wq_wr <= wq_wr + 1'b1;
      if (w_pop) wq_rd <= wq_rd + 1'b1;
      wq_cnt <= wq_cnt + QC_W'(aw_hs) - QC_W'(w_pop);
    end

  // Responses tagged with a non-existent host are dropped; a legal client never sends them.
  always_ff @(posedge clk)
    if (rst_n && (downstream_axi_rvalid || downstream_axi_bvalid)) assert ((!downstream_axi_rvalid || r_ok) && (!downstream_axi_bvalid || b_ok));
endmodule
